// File: rtl/drive_seq_pkg.sv
// Shared types and constants for the drive sequencer: FSM state codes and
// the common counter width.
package drive_seq_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_REFUEL  = 3'd2,
        ST_HALT    = 3'd3,
        ST_ARRIVED = 3'd4
    } drive_state_t;

    // Next value of a saturating up-counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/drive_sequencer_thermal_guard.sv
// Thermal guard: debounces cpu_overheated into a registered shutdown command,
// holds it through a cooldown down-counter, and counts trips.
module thermal_guard
    import drive_seq_pkg::*;
#(
    parameter int OVERHEAT_DEBOUNCE = 4,
    parameter int COOLDOWN_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_overheated,
    output logic             shut_off_computer,
    output logic [CNT_W-1:0] halt_count
);

    localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(OVERHEAT_DEBOUNCE);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES);

    logic [CNT_W-1:0] ot_cnt;
    logic [CNT_W-1:0] cool_cnt;
    logic             trip;
    logic             release_now;

    // The current high sample is the DEB_MAX-th in a row when ot_cnt already
    // holds DEB_MAX-1 of them.
    assign trip        = cpu_overheated && !shut_off_computer &&
                         (ot_cnt >= DEB_MAX - 1'b1);
    assign release_now = !cpu_overheated && shut_off_computer &&
                         (cool_cnt <= 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ot_cnt            <= '0;
            cool_cnt          <= '0;
            shut_off_computer <= 1'b0;
            halt_count        <= '0;
        end else if (cpu_overheated) begin
            ot_cnt <= sat_inc(ot_cnt, DEB_MAX);
            if (shut_off_computer || trip) begin
                cool_cnt <= COOL_LOAD;
            end
            if (trip) begin
                shut_off_computer <= 1'b1;
                halt_count        <= sat_inc(halt_count, CNT_MAX);
            end
        end else begin
            ot_cnt <= '0;
            if (release_now) begin
                shut_off_computer <= 1'b0;
                cool_cnt          <= '0;
            end else if (shut_off_computer) begin
                cool_cnt <= cool_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// Trip controller top: drive FSM and keep_driving register around the
// thermal guard.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | parked, waiting for start
//   DRIVE   | driving, keep_driving asserted
//   REFUEL  | tank empty, drive disabled
//   HALT    | computer shut off, drive disabled
//   ARRIVED | destination reached, waits for arrived to drop
module drive_sequencer
    import drive_seq_pkg::*;
#(
    parameter int OVERHEAT_DEBOUNCE = 4,
    parameter int COOLDOWN_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cpu_overheated,
    input  logic             arrived,
    input  logic             gas_tank_empty,
    output logic             shut_off_computer,
    output logic             keep_driving,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] halt_count
);

    drive_state_t state_q;
    drive_state_t next_state;
    drive_state_t target;

    thermal_guard #(
        .OVERHEAT_DEBOUNCE (OVERHEAT_DEBOUNCE),
        .COOLDOWN_CYCLES   (COOLDOWN_CYCLES)
    ) u_thermal_guard (
        .clk               (clk),
        .reset             (reset),
        .cpu_overheated    (cpu_overheated),
        .shut_off_computer (shut_off_computer),
        .halt_count        (halt_count)
    );

    // Target uses the registered shutdown, so drive drops one edge after a trip.
    always_comb begin
        target = ST_DRIVE;
        if (arrived) begin
            target = ST_ARRIVED;
        end else if (shut_off_computer) begin
            target = ST_HALT;
        end else if (gas_tank_empty) begin
            target = ST_REFUEL;
        end

        next_state = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !arrived) begin
                    next_state = target;
                end
            end
            ST_DRIVE, ST_REFUEL, ST_HALT: begin
                next_state = target;
            end
            ST_ARRIVED: begin
                if (!arrived) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            keep_driving <= 1'b0;
        end else begin
            state_q      <= next_state;
            keep_driving <= (next_state == ST_DRIVE);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with a run-length behavioural model
// checked every cycle, plus hand-computed spot checks.
module tb_drive_sequencer;

    localparam int DEB  = 4;
    localparam int COOL = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cpu_overheated = 1'b0;
    logic       arrived = 1'b0;
    logic       gas_tank_empty = 1'b0;
    logic       shut_off_computer;
    logic       keep_driving;
    logic [2:0] state;
    logic [7:0] halt_count;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    // Model state in plain terms: run lengths of highs/lows and a trip flag.
    int  hi_run = 0;
    int  lo_run = 0;
    bit  m_shut = 1'b0;
    int  m_halt = 0;
    int  m_state = 0;
    bit  m_keep = 1'b0;

    drive_sequencer #(
        .OVERHEAT_DEBOUNCE (DEB),
        .COOLDOWN_CYCLES   (COOL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .cpu_overheated    (cpu_overheated),
        .arrived           (arrived),
        .gas_tank_empty    (gas_tank_empty),
        .shut_off_computer (shut_off_computer),
        .keep_driving      (keep_driving),
        .state             (state),
        .halt_count        (halt_count)
    );

    always #5 clk = ~clk;

    // 0 idle, 1 drive, 2 refuel, 3 halt, 4 arrived
    function automatic int model_next(int cur, bit st, bit arr, bit shut, bit gas);
        int want;
        want = arr ? 4 : (shut ? 3 : (gas ? 2 : 1));
        if (cur == 0) return (st && !arr) ? want : 0;
        if (cur == 4) return arr ? 4 : 0;
        return want;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hi_run = 0; lo_run = 0; m_shut = 0; m_halt = 0; m_state = 0; m_keep = 0;
        end else begin
            m_state = model_next(m_state, start, arrived, m_shut, gas_tank_empty);
            m_keep  = (m_state == 1);
            if (cpu_overheated) begin hi_run++; lo_run = 0; end
            else begin lo_run++; hi_run = 0; end
            if (!m_shut && hi_run >= DEB) begin
                m_shut = 1;
                if (m_halt < 255) m_halt++;
            end else if (m_shut && lo_run >= COOL) begin
                m_shut = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_shut",  int'(shut_off_computer), int'(m_shut));
            chk("model_keep",  int'(keep_driving),      int'(m_keep));
            chk("model_state", int'(state),             m_state);
            chk("model_halt",  int'(halt_count),        m_halt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        chk("reset_state", int'(state), 0);
        chk("reset_keep",  int'(keep_driving), 0);
        chk("reset_shut",  int'(shut_off_computer), 0);
        chk("reset_halt",  int'(halt_count), 0);
        reset = 1'b0;
        model_on = 1'b1;

        // 1: start into DRIVE
        start = 1; tick(1);
        chk("s1_state", int'(state), 1);
        chk("s1_keep",  int'(keep_driving), 1);
        start = 0; tick(3);
        chk("s1_hold",  int'(state), 1);

        // 2: short blip, then real trip and cooldown
        cpu_overheated = 1; tick(3);
        cpu_overheated = 0; tick(1);
        chk("s2_blip_shut", int'(shut_off_computer), 0);
        chk("s2_blip_halt", int'(halt_count), 0);
        cpu_overheated = 1; tick(3);
        chk("s2_pre_trip", int'(shut_off_computer), 0);
        tick(1);
        chk("s2_trip_shut",  int'(shut_off_computer), 1);
        chk("s2_trip_state", int'(state), 1);
        cpu_overheated = 0; tick(1);
        chk("s2_halt_state", int'(state), 3);
        chk("s2_halt_keep",  int'(keep_driving), 0);
        tick(14);
        chk("s2_15_lows", int'(shut_off_computer), 1);
        tick(1);
        chk("s2_release", int'(shut_off_computer), 0);
        chk("s2_still_halt", int'(state), 3);
        tick(1);
        chk("s2_redrive", int'(state), 1);
        chk("s2_rekeep",  int'(keep_driving), 1);
        chk("s2_count",   int'(halt_count), 1);

        // high blip mid-cooldown restarts the full cooldown
        cpu_overheated = 1; tick(4);
        cpu_overheated = 0; tick(8);
        cpu_overheated = 1; tick(1);
        cpu_overheated = 0; tick(15);
        chk("s2_blip_restart", int'(shut_off_computer), 1);
        tick(1);
        chk("s2_blip_release", int'(shut_off_computer), 0);
        tick(1);
        chk("s2_count2", int'(halt_count), 2);

        // 3: refuel
        gas_tank_empty = 1; tick(1);
        chk("s3_refuel", int'(state), 2);
        chk("s3_keep",   int'(keep_driving), 0);
        gas_tank_empty = 0; tick(1);
        chk("s3_drive", int'(state), 1);
        chk("s3_rekeep", int'(keep_driving), 1);

        // 4: arrived beats gas; start ignored in ARRIVED and while arrived in IDLE
        arrived = 1; gas_tank_empty = 1; tick(1);
        chk("s4_arrived", int'(state), 4);
        start = 1; tick(2);
        chk("s4_ign_start", int'(state), 4);
        start = 0; arrived = 0; gas_tank_empty = 0; tick(1);
        chk("s4_idle", int'(state), 0);
        chk("s4_keep", int'(keep_driving), 0);
        arrived = 1; start = 1; tick(1);
        chk("s4_idle_arr", int'(state), 0);
        arrived = 0; tick(1);
        start = 0;
        chk("s4_drive", int'(state), 1);

        // 5: reset in the middle of cooldown
        cpu_overheated = 1; tick(4);
        cpu_overheated = 0; tick(8);
        chk("s5_halt", int'(state), 3);
        reset = 1; tick(1);
        reset = 0;
        chk("s5_rst_state", int'(state), 0);
        chk("s5_rst_shut",  int'(shut_off_computer), 0);
        chk("s5_rst_halt",  int'(halt_count), 0);
        chk("s5_rst_keep",  int'(keep_driving), 0);
        start = 1; tick(1);
        start = 0;
        cpu_overheated = 1; tick(3);
        chk("s5_no_early", int'(shut_off_computer), 0);
        tick(1);
        chk("s5_retrip", int'(shut_off_computer), 1);
        chk("s5_count",  int'(halt_count), 1);
        cpu_overheated = 0; tick(COOL);
        chk("s5_release", int'(shut_off_computer), 0);

        // 6: saturation of halt_count (already 1, so 260 more trips)
        for (int i = 0; i < 260; i++) begin
            cpu_overheated = 1; tick(DEB);
            cpu_overheated = 0; tick(COOL);
        end
        chk("s6_saturate", int'(halt_count), 255);
        tick(2);
        chk("s6_drive", int'(state), 1);

        model_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
